// File: rtl/core_pkg.sv
// Shared types and lane-range helpers for the output-accumulation engine.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        PRIME = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Largest signed value representable in a bw-bit lane.
    function automatic int lane_max(input int unsigned bw);
        return (1 << (bw - 1)) - 1;
    endfunction

    // Smallest signed value representable in a bw-bit lane.
    function automatic int lane_min(input int unsigned bw);
        return -(1 << (bw - 1));
    endfunction

endpackage

// File: rtl/psum_sat_add.sv
// One accumulator lane: pass-through on the first pass, saturating signed add afterwards.
module psum_sat_add
    import core_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                first_pass,
    output logic signed [W-1:0] sum_c
);

    localparam int unsigned SW = W + 1;
    localparam logic signed [SW-1:0] MAX_V = SW'(lane_max(W));
    localparam logic signed [SW-1:0] MIN_V = SW'(lane_min(W));

    logic signed [SW-1:0] exact_c;

    // One extra bit holds the exact sum so the clamp never sees a wrapped value.
    always_comb begin
        exact_c = SW'(a) + SW'(b);
        if (first_pass) begin
            sum_c = b;
        end else if (exact_c > MAX_V) begin
            sum_c = W'(MAX_V);
        end else if (exact_c < MIN_V) begin
            sum_c = W'(MIN_V);
        end else begin
            sum_c = W'(exact_c);
        end
    end

endmodule

// File: rtl/core_accum.sv
// Multi-pass psum accumulator with saturating buffer and ReLU drain over valid/ready.
module core_accum
    import core_pkg::*;
#(
    parameter int unsigned COL     = 8,
    parameter int unsigned PSUM_BW = 16,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned PASS_BW = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PASS_BW-1:0]       num_pass,
    input  logic                     relu_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [COL*PSUM_BW-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COL*PSUM_BW-1:0]   out_data,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned ROW_BITS = COL * PSUM_BW;
    localparam int unsigned ROW_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
    logic [PASS_BW-1:0]    pass_cnt_q, pass_cnt_d;
    logic [PASS_BW-1:0]    last_pass_q, last_pass_d;
    logic                  relu_q, relu_d;
    logic [ROW_BITS-1:0]   out_data_q, out_data_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [ROW_BITS-1:0]   mem_q [DEPTH];
    logic                  mem_we_d;
    logic [ROW_BITS-1:0]   mem_wdata_d;

    logic [ROW_W-1:0]      rd_idx_c;
    logic [ROW_BITS-1:0]   rd_row_c;
    logic [ROW_BITS-1:0]   relu_row_c;
    logic                  first_pass_c;

    // Read the current row while accumulating/priming; look one row ahead while draining.
    always_comb begin
        rd_idx_c = row_cnt_q;
        if (state_q == DRAIN) begin
            rd_idx_c = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + ROW_W'(1);
        end
    end

    assign rd_row_c     = mem_q[rd_idx_c];
    assign first_pass_c = (pass_cnt_q == '0);

    // Per-lane saturating adders on the write path and ReLU on the drain path.
    for (genvar i = 0; i < COL; i++) begin : g_lane
        logic signed [PSUM_BW-1:0] rd_lane;
        logic signed [PSUM_BW-1:0] sum_lane;

        assign rd_lane = rd_row_c[i*PSUM_BW +: PSUM_BW];

        psum_sat_add #(
            .W (PSUM_BW)
        ) u_add (
            .a          (rd_lane),
            .b          (in_data[i*PSUM_BW +: PSUM_BW]),
            .first_pass (first_pass_c),
            .sum_c      (sum_lane)
        );

        assign mem_wdata_d[i*PSUM_BW +: PSUM_BW] = sum_lane;
        assign relu_row_c[i*PSUM_BW +: PSUM_BW]  = (relu_q && rd_lane[PSUM_BW-1]) ? '0 : rd_lane;
    end

    // Next-state, counters, drain register and registered handshake outputs.
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        pass_cnt_d  = pass_cnt_q;
        last_pass_d = last_pass_q;
        relu_d      = relu_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        mem_we_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ACCUM;
                    row_cnt_d   = '0;
                    pass_cnt_d  = '0;
                    last_pass_d = (num_pass == '0) ? '0 : num_pass - PASS_BW'(1);
                    relu_d      = relu_en;
                end
            end
            ACCUM: begin
                if (in_valid && in_ready_q) begin
                    mem_we_d = 1'b1;
                    if (row_cnt_q == ROW_LAST) begin
                        row_cnt_d  = '0;
                        pass_cnt_d = pass_cnt_q + PASS_BW'(1);
                        if (pass_cnt_q == last_pass_q) begin
                            state_d = PRIME;
                        end
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_W'(1);
                    end
                end
            end
            PRIME: begin
                out_data_d = relu_row_c;
                state_d    = DRAIN;
            end
            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (row_cnt_q == ROW_LAST) begin
                        row_cnt_d = '0;
                        state_d   = IDLE;
                        done_d    = 1'b1;
                    end else begin
                        row_cnt_d  = row_cnt_q + ROW_W'(1);
                        out_data_d = relu_row_c;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DRAIN);
        busy_d      = (state_d != IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            pass_cnt_q  <= '0;
            last_pass_q <= '0;
            relu_q      <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            last_pass_q <= last_pass_d;
            relu_q      <= relu_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Accumulation buffer; not cleared by reset since pass 0 always overwrites.
    always_ff @(posedge clk) begin
        if (!reset && mem_we_d) begin
            mem_q[row_cnt_q] <= mem_wdata_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_core_accum.sv
// Randomised scoreboard bench for core_accum against an arithmetic reference model.
module tb_core_accum;

    localparam int unsigned COL      = 8;
    localparam int unsigned PSUM_BW  = 16;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned PASS_BW  = 8;
    localparam int unsigned ROW_BITS = COL * PSUM_BW;
    localparam int LMAX = 32767;
    localparam int LMIN = -32768;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [PASS_BW-1:0]   num_pass;
    logic                 relu_en;
    logic                 in_valid;
    logic                 in_ready;
    logic [ROW_BITS-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ROW_BITS-1:0]  out_data;
    logic                 busy;
    logic                 done;

    always #5 clk = ~clk;

    core_accum #(
        .COL     (COL),
        .PSUM_BW (PSUM_BW),
        .DEPTH   (DEPTH),
        .PASS_BW (PASS_BW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_pass  (num_pass),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [ROW_BITS-1:0] exp_q [$];
    int model [DEPTH][COL];

    int last_acc_cyc = -100;
    int exp_done_cyc = -100;
    int job_row      = 0;
    int ready_mode   = 0;
    int stall_cnt    = 0;
    bit mon_en       = 1'b0;
    bit prev_ov      = 1'b0;
    bit prev_stall   = 1'b0;
    logic [ROW_BITS-1:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [ROW_BITS-1:0] act, input logic [ROW_BITS-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, req, cyc);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > LMAX) return LMAX;
        if (v < LMIN) return LMIN;
        return v;
    endfunction

    function automatic int gen_lane(input int mode, input int p, input int r, input int i);
        case (mode)
            1: return r * 10 + i;
            2: return 100;
            3: begin
                case (i % 3)
                    0:       return 30000;
                    1:       return -30000;
                    default: return (p == 0) ? 5 : -7;
                endcase
            end
            4: begin
                case (i % 4)
                    0:       return -5;
                    1:       return 7;
                    2:       return -32768;
                    default: return 0;
                endcase
            end
            5:       return int'($urandom_range(2000)) - 1000;
            default: return int'($urandom_range(65535)) - 32768;
        endcase
    endfunction

    // Consumer backpressure: always ready, random, or a 3-cycle hold at row 5.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: out_ready = ($urandom_range(99) < 70);
                2: begin
                    if (out_valid && job_row == 5 && stall_cnt < 3) begin
                        out_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: pops the scoreboard on each handshake and checks timing/hold rules.
    always @(negedge clk) begin
        if (mon_en) begin
            if (cyc == exp_done_cyc) begin
                check("done_pulse", {done, busy}, 2'b10);
            end else if (done) begin
                check("done_spurious", done, 1'b0);
            end
            if (out_valid && !prev_ov) begin
                check("prime_latency", ROW_BITS'(cyc - last_acc_cyc), 2);
            end
            if (prev_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_hold", out_data, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_row unexpected actual=%h cyc=%0d", out_data, cyc);
                end else begin
                    check("out_row", out_data, exp_q.pop_front());
                end
                job_row++;
                if (job_row == DEPTH) begin
                    job_row = 0;
                    exp_done_cyc = cyc + 1;
                end
            end
            prev_ov    = out_valid;
            prev_stall = out_valid && !out_ready;
            held       = out_data;
        end
    end

    // Drives one job from a negedge; model update and expected rows come from plain arithmetic.
    task automatic run_job(input int np_drive, input int p_model, input bit relu,
                           input int mode, input int gap_pct, input bit spam);
        int lv [COL];
        int v;
        int guard;
        logic [ROW_BITS-1:0] row;
        logic [ROW_BITS-1:0] e;
        start    = 1'b1;
        num_pass = PASS_BW'(np_drive);
        relu_en  = relu;
        @(negedge clk);
        start = spam;
        if (spam) begin
            num_pass = PASS_BW'($urandom_range(255));
            relu_en  = ~relu;
        end
        check("start_ready", {in_ready, busy}, 2'b11);
        for (int p = 0; p < p_model; p++) begin
            for (int r = 0; r < DEPTH; r++) begin
                while ($urandom_range(99) < gap_pct) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
                for (int i = 0; i < COL; i++) begin
                    lv[i] = gen_lane(mode, p, r, i);
                    row[i*PSUM_BW +: PSUM_BW] = PSUM_BW'(lv[i]);
                end
                in_valid = 1'b1;
                in_data  = row;
                guard    = 0;
                while (!in_ready && guard < 50) begin
                    @(negedge clk);
                    guard++;
                end
                if (!in_ready) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout actual=0 required=1 pass=%0d row=%0d", p, r);
                    in_valid = 1'b0;
                    start    = 1'b0;
                    return;
                end
                for (int i = 0; i < COL; i++) begin
                    model[r][i] = (p == 0) ? lv[i] : clamp(model[r][i] + lv[i]);
                end
                if (p == p_model - 1 && r == DEPTH - 1) begin
                    last_acc_cyc = cyc;
                    for (int rr = 0; rr < DEPTH; rr++) begin
                        for (int i = 0; i < COL; i++) begin
                            v = model[rr][i];
                            if (relu && v < 0) v = 0;
                            e[i*PSUM_BW +: PSUM_BW] = PSUM_BW'(v);
                        end
                        exp_q.push_back(e);
                    end
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((busy || exp_q.size() != 0) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (busy || exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout busy=%0b pending=%0d required busy=0 pending=0", busy, exp_q.size());
        end
        @(negedge clk);
        ready_mode = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        num_pass = '0;
        relu_en  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_rst", {in_ready, out_valid, busy, done}, 4'b0000);
        mon_en = 1'b1;

        // Single pass, ramp data, pass-through order.
        run_job(1, 1, 1'b0, 1, 0, 1'b0);
        wait_idle();
        check("busy_low_after", busy, 1'b0);

        // Three passes of constant 100.
        run_job(3, 3, 1'b0, 2, 0, 1'b0);
        wait_idle();

        // Saturation in both directions plus a small negative result.
        run_job(2, 2, 1'b0, 3, 0, 1'b0);
        wait_idle();

        // ReLU, then buffer reuse without ReLU.
        run_job(1, 1, 1'b1, 4, 0, 1'b0);
        wait_idle();
        run_job(1, 1, 1'b0, 4, 0, 1'b0);
        wait_idle();

        // Input gaps with a 3-cycle output hold at row 5.
        stall_cnt  = 0;
        ready_mode = 2;
        run_job(3, 3, 1'b0, 5, 40, 1'b0);
        wait_idle();

        // Full-range random data with random backpressure on both sides.
        ready_mode = 1;
        run_job(2, 2, 1'b0, 0, 30, 1'b0);
        wait_idle();

        // start held high with different parameters while busy.
        ready_mode = 1;
        run_job(2, 2, 1'b1, 5, 20, 1'b1);
        wait_idle();

        // num_pass of zero acts as a single pass.
        run_job(0, 1, 1'b0, 0, 0, 1'b0);
        wait_idle();

        // Reset in the middle of the first pass, then a fresh single-pass job.
        start    = 1'b1;
        num_pass = PASS_BW'(2);
        relu_en  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < 5; r++) begin
            in_valid = 1'b1;
            for (int i = 0; i < COL; i++) begin
                in_data[i*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom_range(65535));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("mid_reset_idle", {in_ready, busy, out_valid}, 3'b000);
        reset = 1'b0;
        @(negedge clk);
        run_job(1, 1, 1'b0, 0, 0, 1'b0);
        wait_idle();

        // A few fully random jobs.
        for (int j = 0; j < 4; j++) begin
            int np;
            np = int'($urandom_range(1, 4));
            ready_mode = int'($urandom_range(1));
            run_job(np, np, 1'($urandom_range(1)), ($urandom_range(1) == 0) ? 0 : 5,
                    int'($urandom_range(50)), 1'b0);
            wait_idle();
        end

        check("queue_drained", ROW_BITS'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
